// File: rtl/pc_sequencer_if.sv
// Instruction-memory side of the PC sequencer: fetch request, address,
// memory acknowledge and the completed-fetch strobe.
interface pc_sequencer_if #(
    parameter int ARCHITECTURE = 32
);
    logic                    fetch_req_o;
    logic [ARCHITECTURE-1:0] pc_o;
    logic                    imem_ack_i;
    logic                    instr_valid_o;

    modport master (
        output fetch_req_o,
        output pc_o,
        output instr_valid_o,
        input  imem_ack_i
    );

    modport slave (
        input  fetch_req_o,
        input  pc_o,
        input  instr_valid_o,
        output imem_ack_i
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencing with stall, jump/branch redirect and
// misalignment halt; trap redirect and EPC exist only with PC_SEQ_TRAP_EN.
module pc_sequencer #(
    parameter int                    ARCHITECTURE = 32,
    parameter logic [ARCHITECTURE-1:0] RESET_VECTOR = 32'h00000000,
    parameter logic [ARCHITECTURE-1:0] TRAP_VECTOR  = 32'h00000080,
    parameter logic [ARCHITECTURE-1:0] SEQ_INC      = 32'h00000004
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    branch_taken_i,
    input  logic [ARCHITECTURE-1:0] branch_target_i,
    input  logic                    jump_i,
    input  logic [ARCHITECTURE-1:0] jump_target_i,
`ifdef PC_SEQ_TRAP_EN
    input  logic                    trap_i,
    output logic [ARCHITECTURE-1:0] epc_o,
`endif
    output logic                    misaligned_o,
    pc_sequencer_if.master          imem
);

    typedef enum logic [1:0] {
        S_RST,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e                  state_q, state_d;
    logic [ARCHITECTURE-1:0] pc_q, pc_d;
    logic                    trap;
    logic                    redirect;
    logic                    misal;
    logic [ARCHITECTURE-1:0] target;
    state_e                  run_state;

`ifdef PC_SEQ_TRAP_EN
    logic [ARCHITECTURE-1:0] epc_q, epc_d;
    assign trap  = trap_i;
    assign epc_o = epc_q;
`else
    assign trap = 1'b0;
`endif

    assign redirect  = trap | jump_i | branch_taken_i;
    assign target    = trap   ? TRAP_VECTOR :
                       jump_i ? jump_target_i : branch_target_i;
    // Trap vector is trusted; only jump/branch targets can fault.
    assign misal     = !trap && (target[1:0] != 2'b00);
    assign run_state = stall_i ? S_HOLD : S_FETCH;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RST;
            pc_q    <= RESET_VECTOR;
`ifdef PC_SEQ_TRAP_EN
            epc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_SEQ_TRAP_EN
            epc_q   <= epc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_SEQ_TRAP_EN
        epc_d   = epc_q;
`endif
        unique case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH, S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = misal ? S_FAULT : run_state;
`ifdef PC_SEQ_TRAP_EN
                    if (trap) epc_d = pc_q;
`endif
                end else if (state_q == S_FETCH && imem.imem_ack_i) begin
                    pc_d    = pc_q + SEQ_INC;
                    state_d = run_state;
                end else begin
                    state_d = run_state;
                end
            end
            S_FAULT: begin
`ifdef PC_SEQ_TRAP_EN
                if (trap) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VECTOR;
                    state_d = run_state;
                end
`endif
            end
            default: state_d = S_RST;
        endcase
    end

    assign imem.pc_o          = pc_q;
    assign imem.fetch_req_o   = (state_q == S_FETCH);
    assign imem.instr_valid_o = (state_q == S_FETCH) &&
                                imem.imem_ack_i && !redirect;
    assign misaligned_o       = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; trap cases run only
// when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic        misal;
    int          checks;
    int          errors;
`ifdef PC_SEQ_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    pc_sequencer_if #(.ARCHITECTURE(32)) imem ();

    pc_sequencer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (br_tgt),
        .jump_i          (jmp),
        .jump_target_i   (jmp_tgt),
`ifdef PC_SEQ_TRAP_EN
        .trap_i          (trap),
        .epc_o           (epc),
`endif
        .misaligned_o    (misal),
        .imem            (imem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall           = 1'b0;
        br              = 1'b0;
        jmp             = 1'b0;
        imem.imem_ack_i = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        trap            = 1'b0;
`endif
    endtask

    // Advance one rising edge; leave time at negedge + 1.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        br_tgt  = '0;
        jmp_tgt = '0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pc", imem.pc_o, 32'h0);
            chk("rst_req", {31'b0, imem.fetch_req_o}, 32'h0);
            chk("rst_vld", {31'b0, imem.instr_valid_o}, 32'h0);
            chk("rst_mis", {31'b0, misal}, 32'h0);
`ifdef PC_SEQ_TRAP_EN
            chk("rst_epc", epc, 32'h0);
`endif
            if (i < 2) tick();
        end
        rst = 1'b0;
        tick();
        chk("rel_req", {31'b0, imem.fetch_req_o}, 32'h1);
        chk("rel_pc", imem.pc_o, 32'h0);

        // Zero-wait acks
        for (int i = 0; i < 4; i++) begin
            imem.imem_ack_i = 1'b1;
            #1;
            chk("seq_pc", imem.pc_o, 32'(i * 4));
            chk("seq_vld", {31'b0, imem.instr_valid_o}, 32'h1);
            chk("seq_req", {31'b0, imem.fetch_req_o}, 32'h1);
            tick();
        end
        chk("seq_pc4", imem.pc_o, 32'h10);

        // No ack, no stall: PC held
        idle();
        tick();
        chk("noack_pc", imem.pc_o, 32'h10);
        chk("noack_req", {31'b0, imem.fetch_req_o}, 32'h1);

        // Acked fetch at 0x10 with stall for 2 cycles
        imem.imem_ack_i = 1'b1;
        stall           = 1'b1;
        tick();
        chk("stl1_pc", imem.pc_o, 32'h14);
        chk("stl1_req", {31'b0, imem.fetch_req_o}, 32'h0);
        chk("stl1_vld", {31'b0, imem.instr_valid_o}, 32'h0);
        tick();
        chk("stl2_pc", imem.pc_o, 32'h14);
        chk("stl2_req", {31'b0, imem.fetch_req_o}, 32'h0);
        idle();
        tick();
        chk("stlr_req", {31'b0, imem.fetch_req_o}, 32'h1);
        chk("stlr_pc", imem.pc_o, 32'h14);

        // Jump to 0x8 squashes ack
        jmp             = 1'b1;
        jmp_tgt         = 32'h8;
        imem.imem_ack_i = 1'b1;
        #1;
        chk("jmp_vld", {31'b0, imem.instr_valid_o}, 32'h0);
        tick();
        chk("jmp_pc", imem.pc_o, 32'h8);

        // Jump beats branch
        br      = 1'b1;
        br_tgt  = 32'h100;
        jmp_tgt = 32'h200;
        #1;
        chk("pri_vld", {31'b0, imem.instr_valid_o}, 32'h0);
        tick();
        chk("pri_pc", imem.pc_o, 32'h200);
        chk("pri_req", {31'b0, imem.fetch_req_o}, 32'h1);

        // Branch to top of space, then wrap
        idle();
        br     = 1'b1;
        br_tgt = 32'hFFFF_FFFC;
        stall  = 1'b1;
        tick();
        chk("brs_pc", imem.pc_o, 32'hFFFF_FFFC);
        chk("brs_req", {31'b0, imem.fetch_req_o}, 32'h0);
        // Redirect inside HOLD while still stalled
        br_tgt = 32'hFFFF_FFF8;
        tick();
        chk("hbr_pc", imem.pc_o, 32'hFFFF_FFF8);
        chk("hbr_req", {31'b0, imem.fetch_req_o}, 32'h0);
        idle();
        tick();
        imem.imem_ack_i = 1'b1;
        tick();
        chk("wrp_pc0", imem.pc_o, 32'hFFFF_FFFC);
        tick();
        chk("wrp_pc", imem.pc_o, 32'h0);

        // Misaligned jump halts
        idle();
        jmp     = 1'b1;
        jmp_tgt = 32'h102;
        tick();
        idle();
        imem.imem_ack_i = 1'b1;
        br              = 1'b1;
        br_tgt          = 32'h300;
        for (int i = 0; i < 2; i++) begin
            chk("flt_mis", {31'b0, misal}, 32'h1);
            chk("flt_pc", imem.pc_o, 32'h102);
            chk("flt_req", {31'b0, imem.fetch_req_o}, 32'h0);
            chk("flt_vld", {31'b0, imem.instr_valid_o}, 32'h0);
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        chk("frst_pc", imem.pc_o, 32'h0);
        chk("frst_mis", {31'b0, misal}, 32'h0);
        chk("frst_req", {31'b0, imem.fetch_req_o}, 32'h0);
        rst = 1'b0;
        tick();
        chk("frel_req", {31'b0, imem.fetch_req_o}, 32'h1);

`ifdef PC_SEQ_TRAP_EN
        jmp     = 1'b1;
        jmp_tgt = 32'h40;
        tick();
        idle();
        chk("tpre_pc", imem.pc_o, 32'h40);
        trap            = 1'b1;
        imem.imem_ack_i = 1'b1;
        #1;
        chk("trp_vld", {31'b0, imem.instr_valid_o}, 32'h0);
        tick();
        chk("trp_epc", epc, 32'h40);
        chk("trp_pc", imem.pc_o, 32'h80);
        chk("trp_req", {31'b0, imem.fetch_req_o}, 32'h1);
        idle();
        jmp     = 1'b1;
        jmp_tgt = 32'h102;
        tick();
        idle();
        chk("tflt_mis", {31'b0, misal}, 32'h1);
        trap = 1'b1;
        tick();
        idle();
        chk("tex_mis", {31'b0, misal}, 32'h0);
        chk("tex_pc", imem.pc_o, 32'h80);
        chk("tex_epc", epc, 32'h102);
        chk("tex_req", {31'b0, imem.fetch_req_o}, 32'h1);
        // Trap wins over a misaligned jump
        trap    = 1'b1;
        jmp     = 1'b1;
        jmp_tgt = 32'h203;
        stall   = 1'b1;
        tick();
        idle();
        chk("tpri_mis", {31'b0, misal}, 32'h0);
        chk("tpri_pc", imem.pc_o, 32'h80);
        chk("tpri_req", {31'b0, imem.fetch_req_o}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
